feature_mem_reader: RTL
=======================

# feature_mem_reader

Read-side controller for the ping-pong scratchpad feature memories. On a start pulse it streams a run of 128-bit feature lines from the selected group-0/group-1 scratchpad into the line buffer array over a valid/ready interface. It absorbs the scratchpad's one-cycle read latency and line-buffer backpressure, and signals completion to the control FSM.

## Interface
Parameters:
- DATA_BUS_WIDTH, 128, width of one feature memory line and of the output beat.
- GROUP_W, 4, width of the scratchpad group address (address bits [7:4]).
- LINE_W, 4, width of the scratchpad line address (address bits [3:0]).
- FIFO_DEPTH, 3, output buffer entries; fixed at 3, other values unsupported.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse; honoured only in IDLE.
- buffer_sel  in  1  0 = read feature_mem_group_0, 1 = read group_1; latched at start.
- base_addr  in  8  first line address {group,line}; latched at start.
- feature_size  in  8  number of lines to read (0..255); latched at start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the run is complete.
- rd_en_0 / rd_en_1  out  1 each  read strobe to scratchpad 0 / 1.
- rd_mem_group  out  GROUP_W  read group address, shared by both memories.
- rd_mem_line  out  LINE_W  read line address, shared by both memories.
- rd_data_0 / rd_data_1  in  DATA_BUS_WIDTH each  scratchpad read data, valid one cycle after rd_en.
- o_data  out  DATA_BUS_WIDTH  beat to the line buffer.
- o_valid  out  1  o_data valid.
- o_ready  in  1  line buffer accepts the beat; a transfer happens when o_valid && o_ready.
- o_last  out  1  qualifies the final beat of the run.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on start with feature_size != 0. IDLE -> DONE on start with feature_size == 0; no reads are issued and no beats are produced.
- READ:
  - Issues one read per cycle when (fifo occupancy + in-flight reads) < 3.
  - Only the latched memory's rd_en is asserted; the other rd_en stays 0.
  - The address advances after each issued read: line+1; line 15 wraps to 0 with group+1; group 15 wraps to 0, giving mod-256 address wrap.
  - READ -> DRAIN once feature_size reads have been issued.
- DRAIN: no new reads. DRAIN -> DONE when the FIFO is empty, nothing is in flight, and no beat is pending.
- DONE: done = 1 for one cycle, then -> IDLE.
- Read data: one cycle after rd_en, the data from the latched memory is written into the FIFO. The FIFO head drives o_data; o_valid = FIFO not empty.
- o_last: set on the beat whose index equals feature_size-1, tracked by an 8-bit output beat counter.
- start outside IDLE is ignored, and inputs are not re-latched.
- Input changes after start have no effect until the next run.
- An overflow-free FIFO is guaranteed by the credit rule. Any write to a full FIFO is a design error; the bench asserts on it.

## Timing
- Reset values: all outputs 0, address 0, counters 0, FIFO empty, state IDLE.
- Reset mid-run aborts immediately. An in-flight read's data is discarded and no done pulse is generated.
- With start sampled at cycle 0 and o_ready held high:
  - rd_en cycles 1..N at one line per cycle.
  - Beat k is valid at cycle k+3; the last beat (o_last) is at cycle N+2.
  - done at cycle N+3; busy is high over cycles 1..N+3.
- feature_size == 0: busy and done at cycle 1, IDLE at cycle 2.
- o_ready low: the FIFO fills to 3 (occupancy + in-flight ≤ 3), reads stall, and o_data/o_valid hold stable. When o_ready returns, one beat per cycle resumes with no loss or duplication.
- No combinational path from o_ready to rd_en or the address outputs. rd_en and addresses are registered.

## Structure
- Shared header network_para.vh carries DATA_BUS_WIDTH, the GROUP_W/LINE_W split, and the state encoding localparams (IDLE=0, READ=1, DRAIN=2, DONE=3).
- One sub-module: rd_skid_fifo, a 3-entry synchronous FIFO with push, pop, empty, full and count, reset asynchronously by rst.
- The top-level body holds the FSM, address generator, issue counter, in-flight flag, output beat counter and data mux.

## Test plan
- Reset then start with sel=0, base=0x00, size=4, o_ready=1 -> rd_en_0 in cycles 1-4 with addresses 0x00-0x03, beats in cycles 3-6, o_last in cycle 6, done in cycle 7, rd_en_1 never asserted.
- sel=1, base=0x0E, size=4 -> addresses 0x0E, 0x0F, 0x10, 0x11 on memory 1 only; data order is preserved.
- base=0xFE, size=3 -> addresses 0xFE, 0xFF, 0x00 (wrap); 3 beats; done.
- size=20 with o_ready toggling in a 2-low/1-high pattern -> exactly 20 beats in order, no FIFO overflow, o_last only on beat 19, done one cycle after the last transfer.
- size=0 -> done in cycle 1, no rd_en and no o_valid. A second start while busy is ignored.
- rst asserted at cycle 5 of a size=10 run -> all outputs 0 that cycle. A subsequent start with size=2 produces exactly 2 fresh beats and no stale data.

Source files
------------

// File: rtl/feature_mem_reader_pkg.sv
// Shared constants and state encoding for the feature memory read path.
package feature_mem_reader_pkg;

    localparam int FMR_DATA_W     = 128;
    localparam int FMR_GROUP_W    = 4;
    localparam int FMR_LINE_W     = 4;
    localparam int FMR_ADDR_W     = FMR_GROUP_W + FMR_LINE_W;
    localparam int FMR_FIFO_DEPTH = 3;
    localparam int FMR_CNT_W      = $clog2(FMR_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/feature_mem_reader_if.sv
// Valid/ready beat stream from the reader into the line buffer array.
interface feature_mem_reader_if
    import feature_mem_reader_pkg::*;
#(
    parameter int DW = FMR_DATA_W
) ();

    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;

    modport master (output o_data, output o_valid, output o_last, input o_ready);
    modport slave  (input o_data, input o_valid, input o_last, output o_ready);

endinterface

// File: rtl/feature_mem_reader_rd_skid_fifo.sv
// Small synchronous FIFO that soaks up scratchpad read data while the line buffer stalls.
module rd_skid_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 3,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: storage is reset too, so o_data reads 0 after reset instead of stale lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/feature_mem_reader.sv
// Streams a run of feature lines from the selected scratchpad into the line buffer,
// issuing reads only while the skid FIFO has room for everything already requested.
module feature_mem_reader
    import feature_mem_reader_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = FMR_DATA_W,
    parameter int GROUP_W        = FMR_GROUP_W,
    parameter int LINE_W         = FMR_LINE_W,
    parameter int FIFO_DEPTH     = FMR_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      buffer_sel,
    input  logic [7:0]                base_addr,
    input  logic [7:0]                feature_size,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en_0,
    output logic                      rd_en_1,
    output logic [GROUP_W-1:0]        rd_mem_group,
    output logic [LINE_W-1:0]         rd_mem_line,
    input  logic [DATA_BUS_WIDTH-1:0] rd_data_0,
    input  logic [DATA_BUS_WIDTH-1:0] rd_data_1,
    feature_mem_reader_if.master      out_if
);

    localparam int AW = GROUP_W + LINE_W;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [7:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    issued_q, issued_d;
    logic [7:0]    beat_q, beat_d;
    logic          rd0_q, rd0_d, rd1_q, rd1_d;
    logic          rvalid_q;
    logic          busy_q, busy_d, done_q, done_d;

    logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]             fifo_count;
    logic [DATA_BUS_WIDTH-1:0] fifo_din, fifo_dout;
    logic                      rd_any, drain_done, issue_ok;
    logic [2:0]                pending;

    assign rd_any    = rd0_q | rd1_q;
    assign fifo_push = rvalid_q;
    assign fifo_din  = sel_q ? rd_data_1 : rd_data_0;
    assign fifo_pop  = !fifo_empty && out_if.o_ready;

    // Lines that will occupy the FIFO after this edge: stored, landing now, and requested.
    assign pending    = 3'(fifo_count) + 3'(rvalid_q) + 3'(rd_any) - 3'(fifo_pop);
    assign issue_ok   = (pending < 3'(FIFO_DEPTH));
    assign drain_done = !rd_any && !rvalid_q &&
                        ((fifo_count == '0) || (fifo_count == CW'(1) && fifo_pop));

    rd_skid_fifo #(.WIDTH(DATA_BUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        size_d   = size_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        beat_d   = fifo_pop ? beat_q + 8'd1 : beat_q;
        rd0_d    = 1'b0;
        rd1_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = buffer_sel;
                    size_d   = feature_size;
                    beat_d   = '0;
                    issued_d = '0;
                    if (feature_size == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = READ;
                        addr_d   = base_addr;
                        issued_d = 8'd1;
                        rd0_d    = !buffer_sel;
                        rd1_d    = buffer_sel;
                    end
                end
            end
            READ: begin
                if (issued_q == size_q) begin
                    state_d = DRAIN;
                end else if (issue_ok) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 8'd1;
                    rd0_d    = !sel_q;
                    rd1_d    = sel_q;
                end
            end
            DRAIN: if (drain_done) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            issued_q <= '0;
            beat_q   <= '0;
            rd0_q    <= 1'b0;
            rd1_q    <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            beat_q   <= beat_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            rvalid_q <= rd_any;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_en_0      = rd0_q;
    assign rd_en_1      = rd1_q;
    assign rd_mem_group = addr_q[AW-1:LINE_W];
    assign rd_mem_line  = addr_q[LINE_W-1:0];

    assign out_if.o_data  = fifo_dout;
    assign out_if.o_valid = !fifo_empty;
    assign out_if.o_last  = !fifo_empty && (beat_q == size_q - 8'd1);

endmodule
